// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed hex display driver for NUM_DIGITS common-anode
//   seven-segment digits that share one active-low segment bus. A packed hex
//   value (and per-digit decimal points) is captured into shadow registers on
//   a load strobe. A prescaled refresh counter then walks a digit index.
//   Each digit stays selected for REFRESH_DIV clock cycles.
//
//   Optional feature macro: SEG_BLINK_EN
//     defined   -> adds blink_mask input and a blink phase counter; while the
//                  phase is 1, digits flagged in blink_mask are blanked.
//     undefined -> no blink_mask port, no blink counter.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   load        in   capture value/dp_in into the shadow registers (level)
//   value       in   4*NUM_DIGITS packed nibbles, nibble i -> digit i
//   dp_in       in   NUM_DIGITS decimal point requests, active-high
//   blank_mask  in   NUM_DIGITS force-dark mask, active-high, sampled live
//   lz_blank    in   leading-zero blanking enable, sampled live
//   blink_mask  in   NUM_DIGITS blink enables (SEG_BLINK_EN only)
//   seg         out  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
//   digit_sel   out  NUM_DIGITS digit enables, active-low, one-cold
//   frame_done  out  one-cycle pulse aligned with digit 0 after each full scan
// ---------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  // Counter widths are kept at least 1 bit so degenerate parameters
  // (REFRESH_DIV=1, NUM_DIGITS=1) still elaborate cleanly.
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Shadow registers
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wrap_q, wrap_d;

  // Registered outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_q, frame_d;

  // Combinational helpers
  logic                  presc_term;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_vec;
  logic [NUM_DIGITS-1:0] blank_vec;

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Shadow capture: level-sampled load, otherwise hold.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end
  end

  // Refresh prescaler and digit index.
  always_comb begin
    presc_term = (presc_q == PRESC_LAST);
    presc_d    = presc_term ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    wrap_d     = 1'b0;
    if (presc_term) begin
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
    end
  end

`ifdef SEG_BLINK_EN
  always_comb begin
    blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;
  end
`endif

  // Blanking and decode for the currently indexed digit.
  always_comb begin
    // Walk from the most significant nibble down; zero_run stays high while
    // every nibble from the top down to digit i is zero. Digit 0 is exempt
    // so an all-zero value still shows a single "0".
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (shadow_val_q[4*i +: 4] == 4'h0);
      lz_vec[i] = zero_run & (i > 0);
    end

    blank_vec = blank_mask | (lz_blank ? lz_vec : '0);
`ifdef SEG_BLINK_EN
    blank_vec = blank_vec | (blink_phase_q ? blink_mask : '0);
`endif

    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    sel_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = shadow_val_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blank = blank_vec[i];
        sel_d[i]  = 1'b0;
      end
    end

    // A blanked digit stays selected so every digit keeps equal duty cycle.
    seg_d   = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
    dp_d    = cur_blank ? 1'b1 : ~cur_dp;
    // wrap_q marks the edge where the index returned to 0, so the pulse
    // lands together with digit 0's registered outputs.
    frame_d = wrap_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      presc_q       <= '0;
      idx_q         <= '0;
      wrap_q        <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      sel_q         <= '1;
      frame_q       <= 1'b0;
`ifdef SEG_BLINK_EN
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      wrap_q        <= wrap_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      sel_q         <= sel_d;
      frame_q       <= frame_d;
`ifdef SEG_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_done = frame_q;

endmodule
